// File: rtl/ysyx_22040750_bypass_scoreboard.sv
// Operand-bypass and load-use hazard unit placed between ID and ID_EX.
// It tracks the destination tags of in-flight instructions in a shift register.
// Each ID source port takes its operand from the youngest ready producer.
// The unit stalls when the youngest producer is a load whose data is not yet valid.
module ysyx_22040750_bypass_scoreboard #(
  parameter int XLEN             = 64,
  parameter int AW               = 5,
  parameter int NRD              = 2,
  parameter int STAGES           = 3,
  parameter int LOAD_READY_STAGE = 1
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic                   I_pipe_adv,
  input  logic                   I_flush,
  input  logic                   I_issue_valid,
  input  logic [AW-1:0]          I_issue_rd,
  input  logic                   I_issue_wen,
  input  logic                   I_issue_load,
  input  logic [NRD*AW-1:0]      I_rs_addr,
  input  logic [NRD-1:0]         I_rs_used,
  input  logic [NRD*XLEN-1:0]    I_rf_data,
  input  logic [STAGES*XLEN-1:0] I_stage_data,
  output logic [NRD*XLEN-1:0]    O_rs_data,
  output logic                   O_stall,
  output logic [31:0]            O_stall_cnt
);

  logic [STAGES-1:0] ent_valid;
  logic [STAGES-1:0] ent_wen;
  logic [STAGES-1:0] ent_load;
  logic [AW-1:0]     ent_rd [STAGES];
  logic [31:0]       stall_cnt;
  logic [NRD-1:0]    port_hazard;
  logic              stall;

  // Per-port youngest-producer search, operand mux and hazard detection.
  always_comb begin
    logic        hit;
    logic        ready;
    int unsigned hit_s;
    O_rs_data   = '0;
    port_hazard = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      hit   = 1'b0;
      ready = 1'b0;
      hit_s = 0;
      // The first hit in ascending stage order is the youngest producer.
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (!hit && ent_valid[s] && ent_wen[s] && (ent_rd[s] != '0) &&
            (ent_rd[s] == I_rs_addr[p*AW +: AW])) begin
          hit   = 1'b1;
          hit_s = s;
        end
      end
      if (hit) begin
        ready = !ent_load[hit_s] || (hit_s >= LOAD_READY_STAGE);
      end
      if (hit && ready) begin
        O_rs_data[p*XLEN +: XLEN] = I_stage_data[hit_s*XLEN +: XLEN];
      end else begin
        O_rs_data[p*XLEN +: XLEN] = I_rf_data[p*XLEN +: XLEN];
      end
      port_hazard[p] = I_issue_valid && I_rs_used[p] && hit && !ready;
    end
  end

  // A flush squashes the ID instruction, so it can never be the one stalling.
  always_comb begin
    stall = (|port_hazard) && !I_flush;
  end

  // Tracker shift register and stall-cycle counter.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      ent_valid <= '0;
      ent_wen   <= '0;
      ent_load  <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        ent_rd[s] <= '0;
      end
      stall_cnt <= '0;
    end else if (I_pipe_adv) begin
      for (int unsigned s = 1; s < STAGES; s++) begin
        ent_valid[s] <= ent_valid[s-1];
        ent_wen[s]   <= ent_wen[s-1];
        ent_load[s]  <= ent_load[s-1];
        ent_rd[s]    <= ent_rd[s-1];
      end
      ent_valid[0] <= I_issue_valid && !I_flush && !stall;
      ent_wen[0]   <= I_issue_wen;
      ent_load[0]  <= I_issue_load;
      ent_rd[0]    <= I_issue_rd;
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign O_stall     = stall;
  assign O_stall_cnt = stall_cnt;

endmodule
